// File: rtl/fp29i_to_fp16_pack_if.sv
// Handshake and data bundle for the FP29i -> binary16 output packer.
// The slave view belongs to the packer; the master view belongs to whoever feeds
// it words and accepts its results.
interface fp29i_to_fp16_pack_if;
   logic        din_valid;
   logic        din_ready;
   logic        din_uni_sgn;
   logic [5:0]  din_uni_exp;
   logic [21:0] din_uni_man_dn;
   logic        dout_valid;
   logic        dout_ready;
   logic [15:0] dout_fp16;
   logic        dout_ovf;
   logic        dout_unf;
   logic        dout_inx;

   modport master (
      output din_valid, din_uni_sgn, din_uni_exp, din_uni_man_dn, dout_ready,
      input  din_ready, dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx
   );

   modport slave (
      input  din_valid, din_uni_sgn, din_uni_exp, din_uni_man_dn, dout_ready,
      output din_ready, dout_valid, dout_fp16, dout_ovf, dout_unf, dout_inx
   );
endinterface

// File: rtl/fp29i_to_fp16_pack.sv
// FP29i (sign, 6-bit exponent, 22-bit denormalized mantissa) to IEEE binary16
// packer. Three elastic stages: leading-one detect, normalize/denormalize and
// fraction extraction, then round-to-nearest-even and final packing.
// Input value is man * 2^(exp-50); the binary16 biased exponent of the leading
// one is lead + exp - EXP_OFS.
module fp29i_to_fp16_pack #(
   parameter int EXP_OFS    = 35,
   parameter bit SAT_ON_OVF = 1'b0
) (
   input logic                  clk,
   input logic                  rst_n,
   fp29i_to_fp16_pack_if.slave  bus
);

   localparam logic signed [7:0] EXP_OFS_S = 8'(EXP_OFS);

   // Index of the most significant set bit; 0 for an all-zero word.
   function automatic logic [4:0] lead_one(input logic [21:0] m);
      lead_one = 5'd0;
      for (int i = 0; i < 22; i++) begin
         if (m[i]) lead_one = 5'(i);
      end
   endfunction

   // Round-to-nearest, ties-to-even increment decision.
   function automatic logic rne_inc(input logic lsb, input logic guard, input logic sticky);
      rne_inc = guard & (sticky | lsb);
   endfunction

   // Magnitude used when the rounded exponent leaves the finite range.
   function automatic logic [14:0] ovf_mag(input logic sat);
      ovf_mag = sat ? 15'h7BFF : 15'h7C00;
   endfunction

   logic vld_p1, vld_p2, vld_p3;
   logic rdy_p1, rdy_p2, rdy_p3;

   // Stage 1 registers
   logic        sgn_p1;
   logic [5:0]  exp_p1;
   logic [21:0] man_p1;
   logic [4:0]  lead_p1;
   logic        zero_p1;

   // Stage 2 combinational and registers
   logic signed [7:0] e_s2;
   logic signed [7:0] neg_s2;
   logic              tiny_s2;
   logic [4:0]        sh_s2;
   logic [21:0]       norm_s2;
   logic [44:0]       ext_s2;
   logic [6:0]        eeff_s2;

   logic        sgn_p2;
   logic        zero_p2;
   logic        tiny_p2;
   logic [6:0]  eeff_p2;
   logic [9:0]  frac_p2;
   logic        guard_p2;
   logic        sticky_p2;

   // Stage 3 combinational and registers
   logic [10:0] sum_s3;
   logic [6:0]  erd_s3;
   logic [15:0] fp16_s3;
   logic        ovf_s3;
   logic        unf_s3;
   logic        inx_s3;

   logic [15:0] fp16_p3;
   logic        ovf_p3;
   logic        unf_p3;
   logic        inx_p3;

   // A stage can load when empty or when the stage after it is moving on.
   assign rdy_p3        = ~vld_p3 | bus.dout_ready;
   assign rdy_p2        = ~vld_p2 | rdy_p3;
   assign rdy_p1        = ~vld_p1 | rdy_p2;
   assign bus.din_ready = rdy_p1;

   // Stage valid bits: the only state cleared by reset, so a reset drops every word in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
      end else begin
         if (rdy_p1) vld_p1 <= bus.din_valid;
         if (rdy_p2) vld_p2 <= vld_p1;
         if (rdy_p3) vld_p3 <= vld_p2;
      end
   end

   // ---- stage 1: capture input word and locate its leading one ----
   always_ff @(posedge clk) begin
      if (rdy_p1 && bus.din_valid) begin
         sgn_p1  <= bus.din_uni_sgn;
         exp_p1  <= bus.din_uni_exp;
         man_p1  <= bus.din_uni_man_dn;
         lead_p1 <= lead_one(bus.din_uni_man_dn);
         zero_p1 <= (bus.din_uni_man_dn == 22'd0);
      end
   end

   // ---- stage 2: biased exponent, normalize, subnormal right shift, fraction/guard/sticky ----
   always_comb begin
      e_s2    = $signed({3'b000, lead_p1}) + $signed({2'b00, exp_p1}) - EXP_OFS_S;
      tiny_s2 = (e_s2 <= 8'sd0);
      neg_s2  = 8'sd1 - e_s2;
      sh_s2   = 5'd0;
      if (tiny_s2) sh_s2 = (neg_s2 > 8'sd24) ? 5'd24 : neg_s2[4:0];
      norm_s2 = man_p1 << (5'd21 - lead_p1);
      // 24 spare bits below the mantissa catch everything a 24-place shift pushes out.
      ext_s2  = 45'({norm_s2, 24'd0} >> sh_s2);
      eeff_s2 = tiny_s2 ? 7'd0 : e_s2[6:0];
   end

   // Stage 2 register load.
   always_ff @(posedge clk) begin
      if (rdy_p2 && vld_p1) begin
         sgn_p2    <= sgn_p1;
         zero_p2   <= zero_p1;
         tiny_p2   <= tiny_s2;
         eeff_p2   <= eeff_s2;
         frac_p2   <= ext_s2[44:35];
         guard_p2  <= ext_s2[34];
         sticky_p2 <= |ext_s2[33:0];
      end
   end

   // ---- stage 3: round, handle carry/overflow/zero, pack ----
   always_comb begin
      sum_s3  = {1'b0, frac_p2} + {10'd0, rne_inc(frac_p2[0], guard_p2, sticky_p2)};
      // Carry out of the fraction bumps the exponent; a subnormal becomes the min normal.
      erd_s3  = eeff_p2 + {6'd0, sum_s3[10]};
      fp16_s3 = {sgn_p2, erd_s3[4:0], sum_s3[9:0]};
      inx_s3  = guard_p2 | sticky_p2;
      ovf_s3  = 1'b0;
      unf_s3  = tiny_p2 & inx_s3;
      if (zero_p2) begin
         fp16_s3 = {sgn_p2, 15'd0};
         inx_s3  = 1'b0;
         unf_s3  = 1'b0;
      end else if (erd_s3 >= 7'd31) begin
         fp16_s3 = {sgn_p2, ovf_mag(SAT_ON_OVF)};
         ovf_s3  = 1'b1;
         inx_s3  = 1'b1;
      end
   end

   // Stage 3 register load; held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rdy_p3 && vld_p2) begin
         fp16_p3 <= fp16_s3;
         ovf_p3  <= ovf_s3;
         unf_p3  <= unf_s3;
         inx_p3  <= inx_s3;
      end
   end

   // Outputs read as zero whenever no word is presented.
   assign bus.dout_valid = vld_p3;
   assign bus.dout_fp16  = vld_p3 ? fp16_p3 : 16'h0000;
   assign bus.dout_ovf   = vld_p3 & ovf_p3;
   assign bus.dout_unf   = vld_p3 & unf_p3;
   assign bus.dout_inx   = vld_p3 & inx_p3;

endmodule

// File: tb/tb_fp29i_to_fp16_pack.sv
// Bench for fp29i_to_fp16_pack: randomized words against an exact-arithmetic
// reference, scoreboard queue between acceptance and output, random back-pressure,
// and a mid-stream reset. A second instance with saturation enabled sees the same
// traffic.
module tb_fp29i_to_fp16_pack;

   typedef struct packed {
      logic [15:0] ns;
      logic [15:0] sat;
      logic        ovf;
      logic        unf;
      logic        inx;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   rdy_mode = 0;
   exp_t q[$];

   logic        held_v = 1'b0;
   logic [15:0] held_fp;
   logic [2:0]  held_fl;

   fp29i_to_fp16_pack_if ifc();
   fp29i_to_fp16_pack_if ifs();

   fp29i_to_fp16_pack #(.EXP_OFS(35), .SAT_ON_OVF(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(ifc)
   );
   fp29i_to_fp16_pack #(.EXP_OFS(35), .SAT_ON_OVF(1'b1)) u_sat (
      .clk(clk), .rst_n(rst_n), .bus(ifs)
   );

   assign ifs.din_valid      = ifc.din_valid;
   assign ifs.din_uni_sgn    = ifc.din_uni_sgn;
   assign ifs.din_uni_exp    = ifc.din_uni_exp;
   assign ifs.din_uni_man_dn = ifc.din_uni_man_dn;
   assign ifs.dout_ready     = ifc.dout_ready;

   always #5 clk = ~clk;

   // Reference: value = m * 2^(e-50), held exactly as an integer in units of 2^-50.
   // The result quantum is 2^-24 for subnormals, else 2^-10 of the leading power of two.
   function automatic exp_t model(input logic s, input logic [5:0] e, input logic [21:0] m);
      exp_t r;
      logic [127:0] v, k, rem, half;
      int msb, qs, bexp;
      logic tiny;
      r.ns = {s, 15'd0}; r.sat = {s, 15'd0}; r.ovf = 0; r.unf = 0; r.inx = 0;
      if (m == 22'd0) return r;
      v = 128'(m) << e;
      msb = 0;
      for (int i = 0; i < 128; i++) if (v[i]) msb = i;
      tiny = (msb - 50) < -14;
      qs = msb - 10;
      if (qs < 26) qs = 26;
      k    = v >> qs;
      rem  = v - (k << qs);
      half = 128'd1 << (qs - 1);
      r.inx = (rem != 0);
      if (rem > half || (rem == half && k[0])) k = k + 128'd1;
      if (k == 128'd2048) begin k = 128'd1024; qs = qs + 1; end
      bexp = (k < 128'd1024) ? 0 : qs - 25;
      if (bexp >= 31) begin
         r.ns  = {s, 15'h7C00};
         r.sat = {s, 15'h7BFF};
         r.ovf = 1;
         r.inx = 1;
      end else begin
         r.ns  = {s, 5'(bexp), k[9:0]};
         r.sat = r.ns;
      end
      r.unf = tiny & r.inx;
      return r;
   endfunction

   // Consumer back-pressure: 0 always ready, 1 random with occasional 5-cycle stalls, 2 never ready.
   initial begin
      int stall = 0;
      int r;
      ifc.dout_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: ifc.dout_ready = 1'b1;
            2: ifc.dout_ready = 1'b0;
            default: begin
               if (stall > 0) begin
                  ifc.dout_ready = 1'b0;
                  stall--;
               end else begin
                  r = $urandom_range(0, 9);
                  if (r == 0) begin
                     stall = 4;
                     ifc.dout_ready = 1'b0;
                  end else begin
                     ifc.dout_ready = (r > 3);
                  end
               end
            end
         endcase
      end
   end

   // Monitor and scoreboard, sampling mid-cycle.
   always @(negedge clk) begin
      exp_t x;
      if (!rst_n) begin
         checks++;
         if (ifc.dout_valid !== 1'b0 || ifc.dout_fp16 !== 16'h0000 ||
             {ifc.dout_ovf, ifc.dout_unf, ifc.dout_inx} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: got valid=%b fp16=%h flags=%b, want 0/0000/000",
                     ifc.dout_valid, ifc.dout_fp16, {ifc.dout_ovf, ifc.dout_unf, ifc.dout_inx});
         end
         q.delete();
         held_v = 1'b0;
      end else begin
         checks++;
         if (ifc.din_ready !== !(q.size() == 3 && !ifc.dout_ready)) begin
            errors++;
            $display("FAIL din_ready: got %b with %0d in flight, dout_ready=%b", ifc.din_ready,
                     q.size(), ifc.dout_ready);
         end
         if (held_v) begin
            checks++;
            if (ifc.dout_valid !== 1'b1 || ifc.dout_fp16 !== held_fp ||
                {ifc.dout_ovf, ifc.dout_unf, ifc.dout_inx} !== held_fl) begin
               errors++;
               $display("FAIL stall_hold: got v=%b %h/%b, want 1 %h/%b", ifc.dout_valid,
                        ifc.dout_fp16, {ifc.dout_ovf, ifc.dout_unf, ifc.dout_inx}, held_fp, held_fl);
            end
         end
         held_v  = ifc.dout_valid && !ifc.dout_ready;
         held_fp = ifc.dout_fp16;
         held_fl = {ifc.dout_ovf, ifc.dout_unf, ifc.dout_inx};
         if (ifc.dout_valid && ifc.dout_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got %h with nothing in flight", ifc.dout_fp16);
            end else begin
               x = q.pop_front();
               if (ifc.dout_fp16 !== x.ns || ifs.dout_fp16 !== x.sat || ifs.dout_valid !== 1'b1 ||
                   {ifc.dout_ovf, ifc.dout_unf, ifc.dout_inx} !== {x.ovf, x.unf, x.inx}) begin
                  errors++;
                  $display("FAIL result: got %h sat=%h ovf/unf/inx=%b, want %h sat=%h %b",
                           ifc.dout_fp16, ifs.dout_fp16, {ifc.dout_ovf, ifc.dout_unf, ifc.dout_inx},
                           x.ns, x.sat, {x.ovf, x.unf, x.inx});
               end
            end
         end
         if (ifc.din_valid && ifc.din_ready)
            q.push_back(model(ifc.din_uni_sgn, ifc.din_uni_exp, ifc.din_uni_man_dn));
      end
   end

   task automatic send(input logic s, input logic [5:0] e, input logic [21:0] m);
      logic acc;
      int   n = 0;
      ifc.din_uni_sgn    = s;
      ifc.din_uni_exp    = e;
      ifc.din_uni_man_dn = m;
      ifc.din_valid      = 1'b1;
      do begin
         @(negedge clk);
         acc = ifc.din_ready && rst_n;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 500);
      ifc.din_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: din_ready stayed 0 for %0d cycles", n);
      end
   endtask

   task automatic wait_empty();
      int n = 0;
      while (q.size() != 0 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d words still pending, want 0", q.size());
      end
   endtask

   task automatic send_random();
      logic [21:0] m;
      case ($urandom_range(0, 7))
         0:       m = 22'd0;
         1, 2:    m = 22'($urandom);
         3, 4:    m = 22'($urandom) >> $urandom_range(0, 21);
         default: m = ((22'($urandom) & ~22'h3FF) | 22'h200) >> $urandom_range(0, 21);
      endcase
      send(1'($urandom), 6'($urandom_range(0, 63)), m);
   endtask

   initial begin
      rst_n              = 1'b0;
      ifc.din_valid      = 1'b0;
      ifc.din_uni_sgn    = 1'b0;
      ifc.din_uni_exp    = 6'd0;
      ifc.din_uni_man_dn = 22'd0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // directed words: unity, RNE ties, subnormals, overflow, zero, carries
      send(1'b0, 6'd30, 22'h100000);
      send(1'b0, 6'd30, 22'h100200);
      send(1'b0, 6'd30, 22'h100600);
      send(1'b0, 6'd26, 22'h000001);
      send(1'b0, 6'd25, 22'h000003);
      send(1'b0, 6'd63, 22'h3FFFFF);
      send(1'b1, 6'd63, 22'h3FFFFF);
      send(1'b1, 6'd17, 22'h000000);
      send(1'b0, 6'd14, 22'h3FFFFF);
      send(1'b0, 6'd30, 22'h3FFFFF);
      send(1'b0, 6'd44, 22'h3FFFFF);
      send(1'b1, 6'd0,  22'h3FFFFF);
      send(1'b0, 6'd0,  22'h000001);
      wait_empty();

      // 8-word stream under random back-pressure
      rdy_mode = 1;
      for (int i = 0; i < 8; i++) send_random();
      wait_empty();

      // longer randomized run
      for (int i = 0; i < 400; i++) send_random();
      rdy_mode = 0;
      for (int i = 0; i < 100; i++) send_random();
      wait_empty();

      // fill the pipeline with three words, then reset with them in flight
      rdy_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) send_random();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rdy_mode = 0;
      repeat (8) @(posedge clk);
      #1;
      send(1'b0, 6'd30, 22'h100000);
      wait_empty();
      repeat (4) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
